// File: rtl/mul_seq_ctrl.sv
// Shift-and-add sequencer for the EX-stage multiplier: STEP_W multiplier bits per BUSY cycle, low DATA_W product bits.
// Optional build macro MUL_EARLY_OUT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
   parameter int DATA_W = 64,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              start,
   input  logic              flush,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              stall_req,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [1:0]        dbg_state
);

   localparam int N     = DATA_W / STEP_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] a_sh, a_sh_nxt;
   logic [DATA_W-1:0] b_sh, b_sh_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [DATA_W-1:0] result_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] b_digit;
   logic [DATA_W-1:0] partial;
   logic [DATA_W-1:0] acc_step;
   logic [DATA_W-1:0] b_shifted;
   logic              last_step;

   // Handshake: start is the request; the instruction in EX is consumed on the
   // rising edge of any cycle where start is high and stall_req is low (DONE).
   always_comb begin
      b_digit                = '0;
      b_digit[STEP_W-1:0]    = b_sh[STEP_W-1:0];
      partial                = a_sh * b_digit;
      acc_step               = acc + partial;
      b_shifted              = b_sh >> STEP_W;
`ifdef MUL_EARLY_OUT_EN
      last_step              = (cnt == CNT_W'(N - 1)) || (b_shifted == '0);
`else
      last_step              = (cnt == CNT_W'(N - 1));
`endif
   end

   always_comb begin
      state_nxt  = state;
      a_sh_nxt   = a_sh;
      b_sh_nxt   = b_sh;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      result_nxt = result;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               state_nxt = S_BUSY;
               a_sh_nxt  = op_a;
               b_sh_nxt  = op_b;
               acc_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_nxt = S_IDLE;
            end else begin
               acc_nxt  = acc_step;
               a_sh_nxt = a_sh << STEP_W;
               b_sh_nxt = b_shifted;
               cnt_nxt  = cnt + CNT_W'(1);
               if (last_step) begin
                  // result takes the accumulator including the final step's partial product
                  state_nxt  = S_DONE;
                  result_nxt = acc_step;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (enable) begin
         state  <= state_nxt;
         a_sh   <= a_sh_nxt;
         b_sh   <= b_sh_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
      end
   end

   assign busy      = (state == S_BUSY);
   assign done      = (state == S_DONE);
   assign stall_req = ((state == S_IDLE) && start && !flush) || busy;
   assign dbg_state = state;

endmodule
